// File: rtl/tt_pattern_harness_if.sv
// Pin-side bundle for the pattern harness: run control/status plus the
// Tiny Tapeout DUT ports. The harness uses the slave view; whatever hosts the
// harness (controller plus the user design) uses the master view.
interface tt_pattern_harness_if #(
    parameter int IN_W  = 8,
    parameter int BIO_W = 8,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    // run control
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] num_vec;
    logic [SIG_W-1:0] exp_sig;
    // run status
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    // DUT stimulus
    logic [IN_W-1:0]  dut_ui;
    logic [BIO_W-1:0] dut_uio;
    logic             dut_rst_n;
    // DUT response
    logic [IN_W-1:0]  dut_uo;
    logic [BIO_W-1:0] dut_uio_out;
    logic [BIO_W-1:0] dut_uio_oe;

    modport master (
        output start, mode, num_vec, exp_sig,
        output dut_uo, dut_uio_out, dut_uio_oe,
        input  busy, done, pass, signature,
        input  dut_ui, dut_uio, dut_rst_n
    );

    modport slave (
        input  start, mode, num_vec, exp_sig,
        input  dut_uo, dut_uio_out, dut_uio_oe,
        output busy, done, pass, signature,
        output dut_ui, dut_uio, dut_rst_n
    );
endinterface

// File: rtl/tt_pattern_harness.sv
// On-chip stimulus/response harness: resets the user design, applies
// num_vec vectors (LFSR or counting), folds the responses into a MISR and
// flags pass when the final signature equals the expected one.
module tt_pattern_harness #(
    parameter int               IN_W   = 8,
    parameter int               BIO_W  = 8,
    parameter int               SIG_W  = 16,
    parameter int               LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS  = 16'hB400,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
    parameter int               SETTLE  = 1,
    parameter int               RST_CYC = 4,
    parameter int               CNT_W   = 16
) (
    input logic clk,
    input logic rst_n,
    input logic ena,
    tt_pattern_harness_if.slave bus
);
    localparam int S_W  = IN_W + BIO_W;
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    // an all-zero Galois LFSR never leaves zero, so force a live seed
    localparam logic [LFSR_W-1:0] SEED_NZ  = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [RC_W-1:0]   RST_LAST = RC_W'(RST_CYC - 1);
    localparam logic [7:0]        SET_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_DRIVE, S_WAIT, S_CAP, S_DONE
    } state_t;

    state_t             state, state_d;
    logic [RC_W-1:0]    rst_cnt, rst_cnt_d;
    logic [7:0]         wait_cnt, wait_cnt_d;
    logic [CNT_W-1:0]   idx, idx_d;
    logic [LFSR_W-1:0]  lfsr, lfsr_d, lfsr_step;
    logic [SIG_W-1:0]   sig, sig_d, misr_step;
    logic [CNT_W-1:0]   nvec_q;
    logic [SIG_W-1:0]   exp_q;
    logic               start_go;
    logic               load_stim;
    logic [CNT_W:0]     idx_inc;

    logic [S_W-1:0]     idx_word;
    logic [S_W-1:0]     stim_word;
    logic [S_W-1:0]     cap_raw;
    logic [SIG_W-1:0]   cap_word;

    logic [IN_W-1:0]    dut_ui_q;
    logic [BIO_W-1:0]   dut_uio_q;
    logic               dut_rst_n_q;
    logic               busy_q, done_q, pass_q;

    // counting stimulus: vector index fitted to the stimulus width
    if (CNT_W >= S_W) begin : g_idx_trunc
        assign idx_word = idx_d[S_W-1:0];
    end else begin : g_idx_zext
        assign idx_word = {{(S_W-CNT_W){1'b0}}, idx_d};
    end

    // only driven outputs are captured; pins the DUT leaves as inputs read 0
    assign cap_raw = {bus.dut_uio_out & bus.dut_uio_oe, bus.dut_uo};
    if (SIG_W > S_W) begin : g_cap_zext
        assign cap_word = {{(SIG_W-S_W){1'b0}}, cap_raw};
    end else begin : g_cap_eq
        assign cap_word = cap_raw;
    end

    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign misr_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ cap_word;
    assign idx_inc   = {1'b0, idx} + 1'b1;
    assign start_go  = bus.start && (state == S_IDLE || state == S_DONE);

    // stimulus is taken from the values the next vector will use
    assign stim_word = bus.mode ? idx_word : lfsr_d[S_W-1:0];

    // next-state and datapath update for the run sequencer
    always_comb begin
        state_d    = state;
        rst_cnt_d  = rst_cnt;
        wait_cnt_d = wait_cnt;
        idx_d      = idx;
        lfsr_d     = lfsr;
        sig_d      = sig;
        load_stim  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_d   = S_RST;
                    rst_cnt_d = '0;
                    idx_d     = '0;
                    lfsr_d    = SEED_NZ;
                    sig_d     = '1;
                end
            end
            S_RST: begin
                if (rst_cnt == RST_LAST) begin
                    if (nvec_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_DRIVE;
                        load_stim = 1'b1;
                    end
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            S_DRIVE: begin
                wait_cnt_d = '0;
                state_d    = (SETTLE == 0) ? S_CAP : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == SET_LAST) state_d = S_CAP;
                else                      wait_cnt_d = wait_cnt + 1'b1;
            end
            S_CAP: begin
                sig_d  = misr_step;
                idx_d  = idx_inc[CNT_W-1:0];
                lfsr_d = lfsr_step;
                if (idx_inc < {1'b0, nvec_q}) begin
                    state_d   = S_DRIVE;
                    load_stim = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer state, counters, LFSR/MISR and run parameters latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rst_cnt  <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            lfsr     <= SEED_NZ;
            sig      <= '1;
            nvec_q   <= '0;
            exp_q    <= '0;
        end else if (ena) begin
            state    <= state_d;
            rst_cnt  <= rst_cnt_d;
            wait_cnt <= wait_cnt_d;
            idx      <= idx_d;
            lfsr     <= lfsr_d;
            sig      <= sig_d;
            if (start_go) begin
                nvec_q <= bus.num_vec;
                exp_q  <= bus.exp_sig;
            end
        end
    end

    // registered pin outputs and run status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_ui_q    <= '0;
            dut_uio_q   <= '0;
            dut_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (ena) begin
            dut_rst_n_q <= (state_d != S_RST);
            busy_q      <= (state_d inside {S_RST, S_DRIVE, S_WAIT, S_CAP});
            done_q      <= (state_d == S_DONE);
            if (start_go) begin
                // DUT sits in reset with quiet inputs
                dut_ui_q  <= '0;
                dut_uio_q <= '0;
                pass_q    <= 1'b0;
            end else begin
                if (load_stim) begin
                    dut_ui_q  <= stim_word[IN_W-1:0];
                    dut_uio_q <= stim_word[S_W-1:IN_W];
                end
                if (state_d == S_DONE && state != S_DONE)
                    pass_q <= (sig_d == exp_q);
            end
        end
    end

    assign bus.dut_ui    = dut_ui_q;
    assign bus.dut_uio   = dut_uio_q;
    assign bus.dut_rst_n = dut_rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
endmodule

// File: tb/tb_tt_pattern_harness.sv
// Randomized run-level bench for tt_pattern_harness with a cycle-timeline
// reference model and a stand-in user design on the DUT pins.
module tb_tt_pattern_harness;
    localparam int IN_W = 8, BIO_W = 8, SIG_W = 16, CNT_W = 16;
    localparam int SETTLE = 1, RST_CYC = 4;
    localparam logic [15:0] SEED = 16'hACE1, TAPS = 16'hB400, POLY = 16'h1021;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    int   kind = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    tt_pattern_harness_if #(.IN_W(IN_W), .BIO_W(BIO_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

    tt_pattern_harness #(
        .IN_W(IN_W), .BIO_W(BIO_W), .SIG_W(SIG_W), .LFSR_W(16),
        .SEED(SEED), .TAPS(TAPS), .POLY(POLY),
        .SETTLE(SETTLE), .RST_CYC(RST_CYC), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus)
    );

    always #5 clk = ~clk;

    // stand-in user design: 0 = all outputs low, 1 = loopback with uio as inputs,
    // 2 = scrambled outputs with only the upper uio nibble driven
    always_comb begin
        bus.dut_uo      = '0;
        bus.dut_uio_out = '0;
        bus.dut_uio_oe  = '0;
        case (kind)
            1: begin
                bus.dut_uo      = bus.dut_ui;
                bus.dut_uio_out = bus.dut_uio;
            end
            2: begin
                bus.dut_uo      = bus.dut_ui ^ 8'h5A;
                bus.dut_uio_out = ~bus.dut_uio;
                bus.dut_uio_oe  = 8'hF0;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---- reference model, written from the run rules ----
    function automatic logic [15:0] lfsr_at(input int v);
        int l = int'(SEED);
        for (int k = 0; k < v; k++)
            l = (l % 2 == 1) ? ((l / 2) ^ int'(TAPS)) : (l / 2);
        return 16'(l);
    endfunction

    function automatic logic [15:0] stim(input bit md, input int v);
        return md ? 16'(v) : lfsr_at(v);
    endfunction

    function automatic logic [15:0] resp(input logic [15:0] s);
        logic [7:0] hi = s[15:8];
        logic [7:0] lo = s[7:0];
        case (kind)
            1:       return {8'h00, lo};
            2:       return {~hi & 8'hF0, lo ^ 8'h5A};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] sig_model(input bit md, input int n);
        int s = 32'hFFFF;
        for (int v = 0; v < n; v++) begin
            s = s * 2;
            if (s >= 32'h10000) s = (s - 32'h10000) ^ int'(POLY);
            s = s ^ int'(resp(stim(md, v)));
        end
        return 16'(s);
    endfunction

    // {busy, done, dut_rst_n, dut_uio, dut_ui} expected eff cycles after start
    function automatic logic [31:0] exp_pins(input bit md, input int n, input int eff);
        int t_done = 1 + RST_CYC + n * (SETTLE + 2);
        logic b = (eff >= 1) && (eff < t_done);
        logic d = (eff >= t_done);
        logic r = !((eff >= 1) && (eff <= RST_CYC));
        logic [15:0] s = 16'h0000;
        int v;
        if (n > 0 && eff > RST_CYC) begin
            v = (eff - 1 - RST_CYC) / (SETTLE + 2);
            if (v > n - 1) v = n - 1;
            s = stim(md, v);
        end
        return {13'b0, b, d, r, s};
    endfunction

    function automatic logic [31:0] obs_pins();
        return {13'b0, bus.busy, bus.done, bus.dut_rst_n, bus.dut_uio, bus.dut_ui};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pins"}, obs_pins(), 32'h0);
        chk({tag, "_pass"}, 32'(bus.pass), 32'h0);
        chk({tag, "_sig"}, 32'(bus.signature), 32'hFFFF);
    endtask

    // one run: start, follow the timeline cycle by cycle, check result at done;
    // optional ena gap at cycle gap_t and optional async abort at cycle abort_t
    task automatic run(input string tag, input bit md, input int n, input bit match,
                       input int gap_t, input int gap_len, input int abort_t);
        logic [15:0] model = sig_model(md, n);
        logic [15:0] ex = match ? model : (model ^ 16'($urandom_range(1, 65535)));
        int t_done = 1 + RST_CYC + n * (SETTLE + 2);
        int wall, eff, gaps;
        bit reached = 0, en;
        @(negedge clk);
        bus.mode = md; bus.num_vec = 16'(n); bus.exp_sig = ex; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wall = 1; eff = 1; gaps = 0;
        while (wall < t_done + gap_len + 10) begin
            if (eff == abort_t) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals({tag, "_abort_now"});
                @(negedge clk);
                chk_reset_vals({tag, "_abort_next"});
                rst_n = 1'b1;
                reached = 1;
                break;
            end
            chk({tag, "_cyc"}, obs_pins(), exp_pins(md, n, eff));
            if (eff == t_done) begin
                chk({tag, "_latency"}, 32'(wall), 32'(t_done + gap_len));
                chk({tag, "_sig"}, 32'(bus.signature), 32'(model));
                chk({tag, "_pass"}, 32'(bus.pass), 32'(ex == model));
                reached = 1;
                break;
            end
            en = !(gap_len > 0 && eff == gap_t && gaps < gap_len);
            if (!en) gaps++;
            ena = en;
            bus.start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            wall++;
            if (en) eff++;
        end
        ena = 1'b1;
        bus.start = 1'b0;
        if (!reached) chk({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, gl, gt;
        bus.start = 1'b0; bus.mode = 1'b0; bus.num_vec = '0; bus.exp_sig = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_dut_rst_n", 32'(bus.dut_rst_n), 32'h1);

        // single counting vector, all-zero DUT outputs
        kind = 0;
        run("t1", 1'b1, 1, 1'b1, 0, 0, 0);
        chk("t1_sig_const", 32'(bus.signature), 32'hEFDF);
        run("t2_bad", 1'b1, 1, 1'b0, 0, 0, 0);
        run("t2_rerun", 1'b1, 1, 1'b1, 0, 0, 0);
        chk("t2_sig_const", 32'(bus.signature), 32'hEFDF);

        // empty run: reset phase only
        run("t3", 1'b0, 0, 1'b1, 0, 0, 0);
        chk("t3_sig_const", 32'(bus.signature), 32'hFFFF);

        // LFSR stimulus through a loopback DUT
        kind = 1;
        run("t4", 1'b0, 4, 1'b1, 0, 0, 0);

        // ena held low for 5 cycles in the first WAIT
        kind = 2;
        run("t5", 1'b0, 3, 1'b1, RST_CYC + 2, 5, 0);

        // async reset during the capture of vector index 3
        run("t6", 1'b1, 6, 1'b1, 0, 0, 1 + RST_CYC + 3 * (SETTLE + 2) + SETTLE + 1);
        run("t6_after", 1'b1, 2, 1'b1, 0, 0, 0);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(0, 7);
            gl   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            gt   = $urandom_range(1, RST_CYC + n * (SETTLE + 2));
            run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), n,
                1'($urandom_range(0, 1)), gt, gl, 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
